// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, receiver state encoding and baud divider helper.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   // Floored clocks per oversample tick, never below one.
   function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
      int d;
      d = clk_freq / (baud * oversample);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_feeder_if.sv
// Byte write port from the UART receiver into the downstream byte FIFO, plus status.
interface uart_rx_fifo_feeder_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] data;
   logic                 wr_data;
   logic                 frame_err;
   logic                 busy;

   modport master (output data, output wr_data, output frame_err, output busy);
   modport slave  (input  data, input  wr_data, input  frame_err, input  busy);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable by clear.
module uart_baud_tick #(
   parameter int DIV = 325
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CNT_LAST) && !clear;

endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// 8N1 UART receiver with 16x oversampling; emits one write strobe per valid byte to the FIFO.
//
// state    | meaning
// ST_IDLE  | line idle, waiting for a falling edge on the synchronised line
// ST_START | counting to mid start bit, rejecting false starts
// ST_DATA  | sampling eight data bits, one per bit period, LSB first
// ST_STOP  | sampling the stop bit, then strobing the byte or flagging a framing error
module uart_rx_fifo_feeder
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rx_in,
   uart_rx_fifo_feeder_if.master bus
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam int BW  = $clog2(DATA_BITS);
   localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   uart_state_e          state_q, state_d;
   logic                 rx_m_q, rx_s_q, rx_prev_q;
   logic [SW-1:0]        samp_q, samp_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 wr_q, wr_d;
   logic                 ferr_q, ferr_d;
   logic                 baud_clear;
   logic                 tick;

   uart_baud_tick #(.DIV(DIV)) u_baud_tick (
      .clock (clock),
      .reset (reset),
      .clear (baud_clear),
      .tick  (tick)
   );

   always_comb begin
      state_d    = state_q;
      samp_d     = samp_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      data_d     = data_q;
      wr_d       = 1'b0;
      ferr_d     = 1'b0;
      baud_clear = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Edge-triggered so a line stuck low (break) cannot re-arm the receiver.
            if (rx_prev_q && !rx_s_q) begin
               state_d    = ST_START;
               samp_d     = '0;
               baud_clear = 1'b1;
            end
         end
         ST_START: begin
            if (tick) begin
               if (samp_q == SAMP_MID) begin
                  if (rx_s_q) begin
                     state_d = ST_IDLE;
                  end else begin
                     samp_d  = '0;
                     bit_d   = '0;
                     state_d = ST_DATA;
                  end
               end else begin
                  samp_d = samp_q + SW'(1);
               end
            end
         end
         ST_DATA: begin
            // Counter restarted at mid start bit, so a full wrap lands on each bit centre.
            if (tick) begin
               if (samp_q == SAMP_LAST) begin
                  samp_d  = '0;
                  shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                  if (bit_q == BIT_LAST) begin
                     state_d = ST_STOP;
                  end else begin
                     bit_d = bit_q + BW'(1);
                  end
               end else begin
                  samp_d = samp_q + SW'(1);
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (samp_q == SAMP_LAST) begin
                  samp_d  = '0;
                  state_d = ST_IDLE;
                  if (rx_s_q) begin
                     data_d = shift_q;
                     wr_d   = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  samp_d = samp_q + SW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rx_m_q    <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
         samp_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         wr_q      <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_m_q    <= rx_in;
         rx_s_q    <= rx_m_q;
         rx_prev_q <= rx_s_q;
         samp_q    <= samp_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         wr_q      <= wr_d;
         ferr_q    <= ferr_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.wr_data   = wr_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// Bench for uart_rx_fifo_feeder: directed scenarios plus random frames against a byte-level model.
module tb_uart_rx_fifo_feeder;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 100_000;
   localparam int OS       = 16;
   localparam int BIT_CLKS = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic rx_in = 1'b1;

   uart_rx_fifo_feeder_if bus ();

   uart_rx_fifo_feeder #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OS)
   ) dut (
      .clock (clock),
      .reset (reset),
      .rx_in (rx_in),
      .bus   (bus)
   );

   always #10 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: bytes that a correct receiver must hand to the FIFO, in order.
   logic [7:0] exp_q[$];
   logic [7:0] exp_last = 8'h00;
   int         exp_ferr = 0;

   // Observed FIFO contents and pulse statistics.
   logic [7:0] got_q[$];
   int   n_wr = 0;
   int   n_ferr = 0;
   bit   overlap = 1'b0;
   bit   long_pulse = 1'b0;
   bit   busy_seen = 1'b0;
   logic wr_prev = 1'b0;
   logic ferr_prev = 1'b0;
   logic busy_after_wr = 1'b0;

   always @(negedge clock) begin
      if (wr_prev) busy_after_wr = bus.busy;
      if (bus.wr_data) begin
         got_q.push_back(bus.data);
         n_wr++;
      end
      if (bus.frame_err) n_ferr++;
      if (bus.wr_data && bus.frame_err) overlap = 1'b1;
      if ((bus.wr_data && wr_prev) || (bus.frame_err && ferr_prev)) long_pulse = 1'b1;
      if (bus.busy) busy_seen = 1'b1;
      wr_prev   = bus.wr_data;
      ferr_prev = bus.frame_err;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic v, input int n);
      rx_in = v;
      repeat (n) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
      drive(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) drive(b[i], BIT_CLKS);
      drive(stop, BIT_CLKS);
      drive(1'b1, gap);
      if (stop) begin
         exp_q.push_back(b);
         exp_last = b;
      end else begin
         exp_ferr++;
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b1;
      rx_in = 1'b1;
      repeat (5) @(negedge clock);
      reset = 1'b0;
      repeat (200) @(negedge clock);
      n_checks++;
      if (bus.data !== 8'h00) begin
         n_fail++; $display("FAIL reset_data: got %h expected 00", bus.data);
      end
      n_checks++;
      if ({bus.wr_data, bus.frame_err, bus.busy} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got wr=%b ferr=%b busy=%b expected 000",
                            bus.wr_data, bus.frame_err, bus.busy);
      end
      n_checks++;
      if (n_wr + n_ferr !== 0) begin
         n_fail++; $display("FAIL reset_pulses: got %0d expected 0", n_wr + n_ferr);
      end
   endtask

   task automatic test_single();
      int wr0;
      wr0 = n_wr;
      send_frame(8'h02, 1'b1, 20);
      n_checks++;
      if (n_wr - wr0 !== 1) begin
         n_fail++; $display("FAIL single_count: got %0d expected 1", n_wr - wr0);
      end
      n_checks++;
      if (bus.data !== 8'h02) begin
         n_fail++; $display("FAIL single_data: got %h expected 02", bus.data);
      end
      n_checks++;
      if (busy_after_wr !== 1'b0) begin
         n_fail++; $display("FAIL single_busy: got %b expected 0 one clock after strobe", busy_after_wr);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes[3];
      logic [7:0] fifo_exp[4];
      int wr0;
      bytes    = '{8'h06, 8'h0E, 8'h1E};
      fifo_exp = '{8'h02, 8'h06, 8'h0E, 8'h1E};
      wr0 = n_wr;
      for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, BIT_CLKS);
      repeat (20) @(negedge clock);
      n_checks++;
      if (n_wr - wr0 !== 3) begin
         n_fail++; $display("FAIL b2b_count: got %0d expected 3", n_wr - wr0);
      end
      n_checks++;
      if (got_q.size() !== 4) begin
         n_fail++; $display("FAIL b2b_fifo_size: got %0d expected 4", got_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_q[i] !== fifo_exp[i]) begin
               n_fail++; $display("FAIL b2b_fifo[%0d]: got %h expected %h", i, got_q[i], fifo_exp[i]);
            end
         end
      end
   endtask

   task automatic test_frame_err();
      int wr0, fe0;
      wr0 = n_wr;
      fe0 = n_ferr;
      send_frame(8'hA5, 1'b0, 0);
      drive(1'b0, 40);
      n_checks++;
      if (n_ferr - fe0 !== 1) begin
         n_fail++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - fe0);
      end
      n_checks++;
      if (n_wr - wr0 !== 0) begin
         n_fail++; $display("FAIL ferr_no_write: got %0d expected 0", n_wr - wr0);
      end
      n_checks++;
      if (bus.data !== exp_last) begin
         n_fail++; $display("FAIL ferr_data_held: got %h expected %h", bus.data, exp_last);
      end
      drive(1'b1, 40);
      n_checks++;
      if (n_ferr - fe0 !== 1 || n_wr - wr0 !== 0) begin
         n_fail++; $display("FAIL break_no_retrigger: got ferr=%0d wr=%0d expected 1 0",
                            n_ferr - fe0, n_wr - wr0);
      end
   endtask

   task automatic test_false_start();
      int wr0, fe0;
      wr0 = n_wr;
      fe0 = n_ferr;
      busy_seen = 1'b0;
      drive(1'b0, 4);
      drive(1'b1, 40);
      n_checks++;
      if (busy_seen !== 1'b1) begin
         n_fail++; $display("FAIL false_start_entered: got busy_seen=%b expected 1", busy_seen);
      end
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL false_start_idle: got busy=%b expected 0", bus.busy);
      end
      n_checks++;
      if ((n_wr - wr0) + (n_ferr - fe0) !== 0) begin
         n_fail++; $display("FAIL false_start_pulses: got %0d expected 0", (n_wr - wr0) + (n_ferr - fe0));
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b;
      int wr0, fe0;
      b = 8'h55;
      drive(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) drive(b[i], BIT_CLKS);
      drive(b[4], BIT_CLKS / 2);
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL midframe_busy: got %b expected 1", bus.busy);
      end
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({bus.busy, bus.wr_data, bus.frame_err} !== 3'b000) begin
         n_fail++; $display("FAIL midframe_reset: got busy=%b wr=%b ferr=%b expected 000",
                            bus.busy, bus.wr_data, bus.frame_err);
      end
      rx_in = 1'b1;
      reset = 1'b0;
      exp_last = 8'h00;
      repeat (40) @(negedge clock);
      wr0 = n_wr;
      fe0 = n_ferr;
      n_checks++;
      if (bus.data !== 8'h00) begin
         n_fail++; $display("FAIL midframe_data_cleared: got %h expected 00", bus.data);
      end
      send_frame(8'h3C, 1'b1, 20);
      n_checks++;
      if (bus.data !== 8'h3C || n_wr - wr0 !== 1 || n_ferr - fe0 !== 0) begin
         n_fail++; $display("FAIL after_reset_frame: got data=%h wr=%0d ferr=%0d expected 3c 1 0",
                            bus.data, n_wr - wr0, n_ferr - fe0);
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       stop;
      int         gap;
      got_q.delete();
      exp_q.delete();
      exp_ferr = 0;
      n_ferr   = 0;
      for (int k = 0; k < 24; k++) begin
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         gap  = stop ? $urandom_range(0, 40) : BIT_CLKS + $urandom_range(0, 20);
         send_frame(b, stop, gap);
      end
      repeat (40) @(negedge clock);
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL rand_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
         end
      end
      n_checks++;
      if (n_ferr !== exp_ferr) begin
         n_fail++; $display("FAIL rand_ferr: got %0d expected %0d", n_ferr, exp_ferr);
      end
      n_checks++;
      if (bus.data !== exp_last) begin
         n_fail++; $display("FAIL rand_last_data: got %h expected %h", bus.data, exp_last);
      end
      n_checks++;
      if (overlap !== 1'b0 || long_pulse !== 1'b0) begin
         n_fail++; $display("FAIL pulse_shape: got overlap=%b long=%b expected 0 0", overlap, long_pulse);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_err();
      test_false_start();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
